// File: rtl/adder_pkg.sv
// adder_pkg: shared width, state encoding and carry-out helper for adder-forest wrappers
package adder_pkg;
  localparam int DATA_W = 8;
  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;
  function automatic logic cout(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb & b_msb) | ((a_msb | b_msb) & ~s_msb);
  endfunction
endpackage

// File: rtl/adder10_accum_stage_if.sv
// adder10_accum_stage_if: operand stream in, packet result stream out
interface adder10_accum_stage_if
  import adder_pkg::*;
#(parameter int CNT_W = 8);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_carry;
  modport slave (input in_valid, in_data, in_last, out_ready,
                 output in_ready, out_valid, out_sum, out_count, out_carry);
  modport master (output in_valid, in_data, in_last, out_ready,
                  input in_ready, out_valid, out_sum, out_count, out_carry);
endinterface

// File: rtl/adder10_accum_stage.sv
// adder10_accum_stage: sequences operand beats through an external adder into a packet accumulator
module adder10_accum_stage
  import adder_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int MAX_BEATS = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  adder10_accum_stage_if.slave     s,
  output logic [DATA_W-1:0]        add_a,
  output logic [DATA_W-1:0]        add_b,
  input  logic [DATA_W-1:0]        add_sum,
  output logic                     busy
);
  state_t            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              carry_q, carry_d;
  logic              rdy_q;
  logic              beat;
  logic              eop;
  assign add_a       = acc_q;
  assign add_b       = s.in_data;
  assign beat        = s.in_valid && rdy_q;
  assign eop         = s.in_last || (count_q + CNT_W'(1) == CNT_W'(MAX_BEATS));
  assign s.in_ready  = rdy_q;
  assign s.out_valid = state_q == HOLD;
  assign s.out_sum   = acc_q;
  assign s.out_count = count_q;
  assign s.out_carry = carry_q;
  assign busy        = state_q != IDLE;
  // acc/count/carry are already zero in IDLE, so the IDLE load is the same update as an ACC beat
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    carry_d = carry_q;
    if (beat) begin
      acc_d   = add_sum;
      count_d = count_q + CNT_W'(1);
      carry_d = carry_q | cout(add_a[DATA_W-1], add_b[DATA_W-1], add_sum[DATA_W-1]);
      state_d = eop ? HOLD : ACC;
    end else if (state_q == HOLD && s.out_ready) begin
      state_d = IDLE;
      acc_d   = '0;
      count_d = '0;
      carry_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      carry_q <= carry_d;
      rdy_q   <= state_d != HOLD;
    end
  end
endmodule

// File: tb/tb_adder10_accum_stage.sv
// tb_adder10_accum_stage: directed checks of the packet accumulator with a behavioural adder
module tb_adder10_accum_stage;
  import adder_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] add_a, add_b, add_sum;
  logic busy;
  int errors = 0;
  int checks = 0;
  adder10_accum_stage_if #(.CNT_W(8)) bus ();
  adder10_accum_stage #(.CNT_W(8), .MAX_BEATS(4)) dut (
    .clk(clk), .rst_n(rst_n), .s(bus.slave),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .busy(busy)
  );
  assign add_sum = add_a + add_b;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    step();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic pop();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.in_ready, busy, bus.out_carry} !== 4'b0000 || bus.out_sum !== 8'h00 || bus.out_count !== 8'd0) begin
      errors++;
      $display("FAIL reset: valid/ready/busy/carry=%b sum=%h count=%0d want 0000/00/0",
               {bus.out_valid, bus.in_ready, busy, bus.out_carry}, bus.out_sum, bus.out_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_single();
    send(8'h2A, 1'b1);
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.out_carry} !== 3'b100 || bus.out_sum !== 8'h2A || bus.out_count !== 8'd1) begin
      errors++;
      $display("FAIL single: vld/rdy/carry=%b sum=%h count=%0d want 100/2a/1",
               {bus.out_valid, bus.in_ready, bus.out_carry}, bus.out_sum, bus.out_count);
    end
    pop();
    checks++;
    if ({bus.out_valid, bus.in_ready, busy} !== 3'b010) begin
      errors++; $display("FAIL single_pop: vld/rdy/busy=%b want 010", {bus.out_valid, bus.in_ready, busy});
    end
  endtask

  task automatic test_three();
    bus.out_ready = 1'b1;
    send(8'h10, 1'b0);
    checks++;
    if ({bus.out_valid, bus.in_ready, busy} !== 3'b011) begin
      errors++; $display("FAIL three_mid: vld/rdy/busy=%b want 011", {bus.out_valid, bus.in_ready, busy});
    end
    send(8'h20, 1'b0);
    send(8'h30, 1'b1);
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.out_carry} !== 3'b100 || bus.out_sum !== 8'h60 || bus.out_count !== 8'd3) begin
      errors++;
      $display("FAIL three: vld/rdy/carry=%b sum=%h count=%0d want 100/60/3",
               {bus.out_valid, bus.in_ready, bus.out_carry}, bus.out_sum, bus.out_count);
    end
    step();
    bus.out_ready = 1'b0;
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      errors++; $display("FAIL three_bubble: vld/rdy=%b want 01", {bus.out_valid, bus.in_ready});
    end
  endtask

  task automatic test_wrap();
    send(8'hF0, 1'b0);
    send(8'h20, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 8'h10 || bus.out_carry !== 1'b1 || bus.out_count !== 8'd2) begin
      errors++;
      $display("FAIL wrap: vld=%b sum=%h carry=%b count=%0d want 1/10/1/2",
               bus.out_valid, bus.out_sum, bus.out_carry, bus.out_count);
    end
    pop();
    send(8'h01, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 8'h01 || bus.out_carry !== 1'b0 || bus.out_count !== 8'd1) begin
      errors++;
      $display("FAIL wrap_sticky_clear: vld=%b sum=%h carry=%b count=%0d want 1/01/0/1",
               bus.out_valid, bus.out_sum, bus.out_carry, bus.out_count);
    end
    pop();
  endtask

  task automatic test_back_to_back();
    send(8'h33, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({bus.out_valid, bus.in_ready} !== 2'b10 || bus.out_sum !== 8'h33 || bus.out_count !== 8'd1) begin
        errors++;
        $display("FAIL hold_stable[%0d]: vld/rdy=%b sum=%h count=%0d want 10/33/1",
                 i, {bus.out_valid, bus.in_ready}, bus.out_sum, bus.out_count);
      end
    end
    pop();
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      errors++; $display("FAIL hold_release: vld/rdy=%b want 01", {bus.out_valid, bus.in_ready});
    end
    step();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 8'h55 || bus.out_count !== 8'd1) begin
      errors++;
      $display("FAIL hold_next_packet: vld=%b sum=%h count=%0d want 1/55/1", bus.out_valid, bus.out_sum, bus.out_count);
    end
    pop();
  endtask

  task automatic test_max_beats();
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_count !== 8'd3) begin
      errors++; $display("FAIL max_beats_pre: vld=%b count=%0d want 0/3", bus.out_valid, bus.out_count);
    end
    send(8'h04, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 8'h0A || bus.out_count !== 8'd4) begin
      errors++;
      $display("FAIL max_beats: vld=%b sum=%h count=%0d want 1/0a/4", bus.out_valid, bus.out_sum, bus.out_count);
    end
    pop();
    send(8'h05, 1'b0);
    send(8'h06, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 8'h0B || bus.out_count !== 8'd2) begin
      errors++;
      $display("FAIL max_beats_next: vld=%b sum=%h count=%0d want 1/0b/2", bus.out_valid, bus.out_sum, bus.out_count);
    end
    pop();
  endtask

  task automatic test_reset_mid();
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.in_ready, busy, bus.out_carry} !== 4'b0000 || bus.out_sum !== 8'h00 || bus.out_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid: vld/rdy/busy/carry=%b sum=%h count=%0d want 0000/00/0",
               {bus.out_valid, bus.in_ready, busy, bus.out_carry}, bus.out_sum, bus.out_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    send(8'h05, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_sum !== 8'h05 || bus.out_count !== 8'd1) begin
      errors++;
      $display("FAIL reset_mid_after: vld=%b sum=%h count=%0d want 1/05/1", bus.out_valid, bus.out_sum, bus.out_count);
    end
    pop();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_single();
    test_three();
    test_wrap();
    test_back_to_back();
    test_max_beats();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/adder10_accum_stage.md
Name: adder10_accum_stage

Overview:
- Streaming accumulator that sits directly around the 8-bit prefix adder (adder10).
- Sequences operand beats from a valid/ready stream onto the adder's a_in/b_in.
- Registers the adder's sum back into a running accumulator each beat.
- Presents the final packet total, beat count and sticky carry-out on a valid/ready output.
- The adder itself stays combinational and is instantiated by the parent. This block only drives its inputs and consumes its sum.

Parameters:
- DATA_W, 8, operand/sum width; must equal the adder width.
- CNT_W, 8, beat counter width.
- MAX_BEATS, 255, packet length cap. Reaching it forces end-of-packet. Range 1..2^CNT_W-1.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  DATA_W  operand
- in_last  in  1  final beat of packet
- add_a  out  DATA_W  to adder a_in; equals accumulator register
- add_b  out  DATA_W  to adder b_in; equals in_data
- add_sum  in  DATA_W  from adder sum (combinational a+b mod 2^DATA_W)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_sum  out  DATA_W  packet total mod 2^DATA_W
- out_count  out  CNT_W  beats accumulated in packet
- out_carry  out  1  sticky: any beat produced carry-out of MSB
- busy  out  1  packet in progress (state ACC or HOLD)

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; acc=0, count=0, carry=0.
  - out_valid=0, in_ready=0 during reset; out_sum=0, out_count=0, out_carry=0, busy=0.
- Release from reset: registers update on the first clk edge after rst_n rises.
- States IDLE, ACC, HOLD:
  - IDLE: in_ready=1, acc=0. An accepted beat (in_valid&in_ready) loads acc<=add_sum (= in_data, since add_a=0), count<=1, carry<=0. Then go to HOLD if in_last or MAX_BEATS==1, else ACC.
  - ACC: in_ready=1. An accepted beat does acc<=add_sum, count<=count+1, carry<=carry|cout. Go to HOLD if in_last or count+1==MAX_BEATS. With no beat, state holds indefinitely.
  - HOLD: in_ready=0, out_valid=1. out_sum/out_count/out_carry are stable until out_ready. On out_valid&out_ready, go to IDLE and clear acc/count/carry.
- Carry derivation: cout = (a7&b7) | ((a7|b7) & ~s7), where a=add_a, b=add_b, s=add_sum.
  - The adder has no carry port, so the carry is computed here.
  - Overflow beyond DATA_W is wrap-around; out_sum is mod 256.
- Latency: the beat accepted at edge N with in_last=1 gives out_valid=1 after edge N (visible cycle N+1), sum including that beat. Throughput is 1 beat/cycle in ACC.
- Bubble cycle: no beat is accepted in HOLD, so there is one bubble per packet minimum.
- Combinational paths:
  - add_a/add_b are pure wiring; the adder path is a single-cycle combinational path into acc.
  - in_ready depends only on state, never on in_valid.
  - out_valid depends only on state, never on out_ready.
- Boundary conditions:
  - A single-beat packet is valid (count=1).
  - in_last on a MAX_BEATS-th beat behaves as one end-of-packet.
  - in_valid held during HOLD is ignored and not consumed.
  - out_ready asserted outside HOLD has no effect.
  - Reset mid-packet discards the partial sum with no output.
- Outputs are registered: out_sum=acc, out_count=count, out_carry=carry, all valid only when out_valid=1.

Decomposition:
- Shared package adder_pkg holds:
  - DATA_W=8 constant.
  - State enum {IDLE, ACC, HOLD}.
  - A carry-out function cout(a_msb, b_msb, s_msb), reused by other adder-forest wrappers.
- No internal sub-module. The FSM and datapath registers are flat.
- The adder10 instance lives in the parent (or testbench) and connects add_a/add_b/add_sum.

Test Plan:
- Single beat: in_data=0x2A, in_last=1 → next cycle out_valid=1, out_sum=0x2A, out_count=1, out_carry=0.
- Three beats 0x10, 0x20, 0x30 (last on third), out_ready=1 → out_sum=0x60, out_count=3, out_carry=0; in_ready=0 for exactly one cycle.
- Wrap: beats 0xF0, 0x20 → out_sum=0x10, out_carry=1. Then packet 0x01 → out_carry=0 (sticky cleared per packet).
- Backpressure: out_ready=0 for 5 cycles in HOLD with in_valid=1, data=0x55 → outputs stable, no beat consumed. On out_ready=1, the next packet starts with 0x55.
- MAX_BEATS=4, in_last never asserted, beats 1,2,3,4 → out_valid after 4th, out_sum=0x0A, out_count=4. A 5th beat starts a new packet.
- Reset asserted mid-packet after beats 0x11, 0x22 → all outputs 0 immediately (asynchronous). After release, packet 0x05/last → out_sum=0x05, out_count=1.
